// File: rtl/signed_divide_by_power_of_2_pipelined_if.sv
// Valid/ready bus for the signed divide-by-2^s stage: upstream dividend/shift in,
// downstream quotient/remainder out.
interface signed_divide_by_power_of_2_pipelined_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) ();
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_a;
    logic [SW-1:0] up_s;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_q;
    logic [N-1:0]  down_r;

    modport master (
        output up_valid, up_a, up_s, down_ready,
        input  up_ready, down_valid, down_q, down_r
    );

    modport slave (
        input  up_valid, up_a, up_s, down_ready,
        output up_ready, down_valid, down_q, down_r
    );
endinterface

// File: rtl/signed_divide_by_power_of_2_pipelined.sv
// Two-stage valid/ready signed division by 2^s, quotient truncated toward zero,
// remainder carries the sign of the dividend.
module signed_divide_by_power_of_2_pipelined #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input logic clk,
    input logic rst_n,
    signed_divide_by_power_of_2_pipelined_if.slave bus_io
);

    logic          v1_q, v1_d;
    logic [N-1:0]  a1_q, a1_d;
    logic [N-1:0]  b1_q, b1_d;
    logic [SW-1:0] s1_q, s1_d;

    logic          v2_q, v2_d;
    logic [N-1:0]  q2_q, q2_d;
    logic [N-1:0]  r2_q, r2_d;

    logic          ld1_s;
    logic          ld2_s;
    logic signed [N-1:0] quot_s;
    logic [N-1:0]  rem_s;

    // Ones in the low s bits: the bias that turns floor-shift into truncation.
    function automatic logic [N-1:0] low_mask(input logic [SW-1:0] s);
        low_mask = ~({N{1'b1}} << s);
    endfunction

    assign ld2_s = !v2_q || bus_io.down_ready;
    assign ld1_s = !v1_q || ld2_s;

    assign bus_io.up_ready   = ld1_s;
    assign bus_io.down_valid = v2_q;
    assign bus_io.down_q     = q2_q;
    assign bus_io.down_r     = r2_q;

    // Stage 1 next state: capture dividend and add the bias to negative dividends.
    always_comb begin
        v1_d = v1_q;
        a1_d = a1_q;
        s1_d = s1_q;
        b1_d = b1_q;
        if (ld1_s) begin
            v1_d = bus_io.up_valid;
            if (bus_io.up_valid) begin
                a1_d = bus_io.up_a;
                s1_d = bus_io.up_s;
                b1_d = bus_io.up_a + (bus_io.up_a[N-1] ? low_mask(bus_io.up_s) : {N{1'b0}});
            end else begin
                a1_d = a1_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    assign quot_s = $signed(b1_q) >>> s1_q;
    assign rem_s  = a1_q - (quot_s << s1_q);

    // Stage 2 next state: arithmetic shift of the biased value, exact remainder.
    always_comb begin
        v2_d = v2_q;
        q2_d = q2_q;
        r2_d = r2_q;
        if (ld2_s) begin
            v2_d = v1_q;
            if (v1_q) begin
                q2_d = quot_s;
                r2_d = rem_s;
            end else begin
                q2_d = q2_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a1_q <= {N{1'b0}};
            b1_q <= {N{1'b0}};
            s1_q <= {SW{1'b0}};
            v2_q <= 1'b0;
            q2_q <= {N{1'b0}};
            r2_q <= {N{1'b0}};
        end else begin
            v1_q <= v1_d;
            a1_q <= a1_d;
            b1_q <= b1_d;
            s1_q <= s1_d;
            v2_q <= v2_d;
            q2_q <= q2_d;
            r2_q <= r2_d;
        end
    end

endmodule

// File: tb/tb_signed_divide_by_power_of_2_pipelined.sv
// Scoreboard bench for the pipelined signed divide-by-2^s stage; expected results
// come from integer C-style division in the bench.
module tb_signed_divide_by_power_of_2_pipelined;

    localparam int N  = 8;
    localparam int SW = 3;

    typedef struct {
        logic [N-1:0]  a;
        logic [SW-1:0] s;
        logic [N-1:0]  q;
        logic [N-1:0]  r;
        int            stamp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   ready_pct;
    int   idle_pct;
    bit   lat_chk;
    bit   prev_stall;
    logic [N-1:0] prev_q;
    logic [N-1:0] prev_r;
    exp_t exp_q[$];
    logic [2*N-1:0] dir_q[$];

    signed_divide_by_power_of_2_pipelined_if #(.N(N), .SW(SW)) bus ();

    signed_divide_by_power_of_2_pipelined #(.N(N), .SW(SW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [N-1:0] a, input logic [SW-1:0] s,
                                    output logic [N-1:0] q, output logic [N-1:0] r);
        int ai;
        int p;
        ai = int'($signed(a));
        p  = 1 << s;
        q  = N'(ai / p);
        r  = N'(ai % p);
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // down_ready driver
    initial begin
        bus.down_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.down_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: pushes expected on accept, pops and compares on emit.
    initial begin
        exp_t e;
        logic [N-1:0] mq;
        logic [N-1:0] mr;
        int ai, qi, ri, p;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (!(bus.down_valid && bus.down_q == prev_q && bus.down_r == prev_r)) begin
                        bad++;
                        $display("FAIL stall_hold got v=%0b q=%0d r=%0d want v=1 q=%0d r=%0d",
                                 bus.down_valid, $signed(bus.down_q), $signed(bus.down_r),
                                 $signed(prev_q), $signed(prev_r));
                    end
                end
                if (bus.down_valid && bus.down_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out got q=%0d r=%0d want no output",
                                 $signed(bus.down_q), $signed(bus.down_r));
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.down_q != e.q || bus.down_r != e.r) begin
                            bad++;
                            $display("FAIL result a=%0d s=%0d got q=%0d r=%0d want q=%0d r=%0d",
                                     $signed(e.a), e.s, $signed(bus.down_q), $signed(bus.down_r),
                                     $signed(e.q), $signed(e.r));
                        end
                        ai = int'($signed(e.a));
                        qi = int'($signed(bus.down_q));
                        ri = int'($signed(bus.down_r));
                        p  = 1 << e.s;
                        total++;
                        if (!((qi * p + ri == ai) && (ri < p) && (ri > -p) &&
                              (ri == 0 || ((ri < 0) == (ai < 0))))) begin
                            bad++;
                            $display("FAIL identity a=%0d s=%0d got q=%0d r=%0d want q*2^s+r=a",
                                     ai, e.s, qi, ri);
                        end
                        if (lat_chk) check("latency", cyc - e.stamp, 2);
                    end
                end
                if (bus.up_valid && bus.up_ready) begin
                    e.a = bus.up_a;
                    e.s = bus.up_s;
                    e.stamp = cyc;
                    if (dir_q.size() != 0) begin
                        {e.q, e.r} = dir_q.pop_front();
                    end else begin
                        ref_div(bus.up_a, bus.up_s, mq, mr);
                        e.q = mq;
                        e.r = mr;
                    end
                    exp_q.push_back(e);
                end
                prev_stall = bus.down_valid && !bus.down_ready;
                prev_q = bus.down_q;
                prev_r = bus.down_r;
            end
        end
    end

    // Issue one transaction; called and returns at posedge+1.
    task automatic send(input logic [N-1:0] a, input logic [SW-1:0] s);
        bit done;
        done = 1'b0;
        while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
            @(posedge clk);
            #1;
        end
        bus.up_valid = 1'b1;
        bus.up_a = a;
        bus.up_s = s;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            done = bus.up_ready;
            @(posedge clk);
            #1;
        end
        bus.up_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_dir(input int a, input int s, input int q, input int r);
        dir_q.push_back({N'(q), N'(r)});
        send(N'(a), SW'(s));
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_down_valid"}, int'(bus.down_valid), 0);
        check({tag, "_down_q"}, int'(bus.down_q), 0);
        check({tag, "_down_r"}, int'(bus.down_r), 0);
        check({tag, "_up_ready"}, int'(bus.up_ready), 1);
    endtask

    initial begin
        int acc;
        bit fire;
        total = 0;
        bad = 0;
        cyc = 0;
        ready_pct = 100;
        idle_pct = 0;
        lat_chk = 1'b0;
        prev_stall = 1'b0;
        rst_n = 1'b0;
        bus.up_valid = 1'b0;
        bus.up_a = '0;
        bus.up_s = '0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        send_dir(-7, 1, -3, -1);
        send_dir(7, 1, 3, 1);
        send_dir(-1, 3, 0, -1);
        send_dir(-128, 7, -1, 0);
        drain();

        for (int a = 0; a < 256; a++) send(N'(a), SW'(0));
        for (int a = 0; a < 256; a++)
            for (int s = 0; s < N; s++) send(N'(a), SW'(s));
        drain();
        lat_chk = 1'b0;

        ready_pct = 0;
        @(posedge clk);
        #1;
        acc = 0;
        bus.up_valid = 1'b1;
        bus.up_a = N'($urandom);
        bus.up_s = SW'($urandom_range(N - 1));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fire = bus.up_valid && bus.up_ready;
            if (fire) acc++;
            @(posedge clk);
            #1;
            if (fire) begin
                bus.up_a = N'($urandom);
                bus.up_s = SW'($urandom_range(N - 1));
            end
        end
        check("bp_accepts", acc, 2);
        check("bp_up_ready_low", int'(bus.up_ready), 0);
        bus.up_valid = 1'b0;
        ready_pct = 100;
        #2;
        check("bp_up_ready_rise", int'(bus.up_ready && bus.down_ready), 1);
        drain();

        ready_pct = 50;
        idle_pct = 50;
        for (int i = 0; i < 10000; i++) send(N'($urandom), SW'($urandom_range(N - 1)));
        idle_pct = 0;
        ready_pct = 100;
        drain();

        ready_pct = 0;
        @(posedge clk);
        #1;
        send(N'(-100), SW'(2));
        send(N'(55), SW'(3));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_pct = 100;
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        send_dir(-128, 1, -64, 0);
        send_dir(127, 6, 1, 63);
        send_dir(-127, 6, -1, -63);
        send_dir(-2, 7, 0, -2);
        drain();
        lat_chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
